detect_tracker: RTL and testbench

//  Downstream of the camera capture/detection stage. Watches the pixel-write stream (we/addr) for end of frame.
//  At each frame end it samples that stage's per-frame result (found flag + linear pixel address).

---
 rtl/detect_tracker_pkg.sv | 19 +
 rtl/detect_tracker_addr_to_xy.sv | 50 +++++
 rtl/detect_tracker.sv | 140 ++++++++++++++
 tb/tb_detect_tracker.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/detect_tracker_pkg.sv
// Shared frame geometry, coordinate widths and FSM encoding for detect_tracker.
package detect_tracker_pkg;

  localparam int FRAME_W      = 640;
  localparam int FRAME_H      = 480;
  localparam int ADDR_W       = 20;
  localparam int FRAME_PIXELS = FRAME_W * FRAME_H;
  localparam int X_W          = 10;
  localparam int Y_W          = 9;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SAMPLE = 3'd1,
    ST_DIVIDE = 3'd2,
    ST_FILTER = 3'd3,
    ST_LOST   = 3'd4
  } state_t;

endpackage

// File: rtl/detect_tracker_addr_to_xy.sv
// Sequential subtract divider: linear pixel address -> (x, y).
// A start pulse loads the address; one line width is subtracted per cycle
// until the remainder is below FRAME_W. done pulses for one cycle with x/y
// valid, y+1 cycles after start.
module detect_tracker_addr_to_xy
  import detect_tracker_pkg::*;
(
  input  logic              pclk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  output logic              done,
  output logic [X_W-1:0]    x,
  output logic [Y_W-1:0]    y
);

  localparam logic [ADDR_W-1:0] LINE_W = ADDR_W'(FRAME_W);

  logic [ADDR_W-1:0] rem;
  logic              run;

  // Repeated line-width subtraction; y counts whole lines removed.
  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      rem  <= '0;
      y    <= '0;
      run  <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem <= addr;
        y   <= '0;
        run <= 1'b1;
      end else if (run) begin
        if (rem >= LINE_W) begin
          rem <= rem - LINE_W;
          y   <= y + 1'b1;
        end else begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  // Once the loop exits the remainder is below FRAME_W and fits in X_W bits.
  assign x = rem[X_W-1:0];

endmodule

// File: rtl/detect_tracker.sv
// detect_tracker: samples the detection stage's per-frame result at each
// frame end, converts the hit address to (x, y), and tracks target lock/loss.
// Optional feature: define DETECT_SMOOTH_EN to enable exponential smoothing
// of the tracked coordinates (c <= c + ((m - c) >>> SMOOTH_SH)).
module detect_tracker
  import detect_tracker_pkg::*;
#(
  parameter int LOST_MAX  = 8,
  parameter int SMOOTH_SH = 2
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic              pix_we,
  input  logic [ADDR_W-1:0] pix_addr,
  input  logic              det_found,
  input  logic [ADDR_W-1:0] det_addr,
  output logic [X_W-1:0]    coord_x,
  output logic [Y_W-1:0]    coord_y,
  output logic              coord_valid,
  output logic              target_lock,
  output logic [3:0]        lost_count,
  output logic              busy,
  output logic              overrun
);

  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(FRAME_PIXELS - 1);
  localparam logic [ADDR_W-1:0] PIX_CNT  = ADDR_W'(FRAME_PIXELS);
  localparam logic [3:0]        LOST_LIM = 4'(LOST_MAX);

  state_t         state;
  logic           fe;
  logic           hit;
  logic           div_start;
  logic           div_done;
  logic [X_W-1:0] div_x;
  logic [Y_W-1:0] div_y;

  // Lost-frame counter increment, saturating at LOST_MAX.
  function automatic logic [3:0] sat_inc(input logic [3:0] c);
    return (c >= LOST_LIM) ? LOST_LIM : c + 4'd1;
  endfunction

  // One smoothing step on x: signed difference at X_W+1 bits, arithmetic shift.
  function automatic logic [X_W-1:0] smooth_x(input logic [X_W-1:0] c,
                                              input logic [X_W-1:0] m);
    logic signed [X_W:0] d;
    logic signed [X_W:0] s;
    d = $signed({1'b0, m}) - $signed({1'b0, c});
    s = $signed({1'b0, c}) + (d >>> SMOOTH_SH);
    return s[X_W-1:0];
  endfunction

  // One smoothing step on y: signed difference at Y_W+1 bits, arithmetic shift.
  function automatic logic [Y_W-1:0] smooth_y(input logic [Y_W-1:0] c,
                                              input logic [Y_W-1:0] m);
    logic signed [Y_W:0] d;
    logic signed [Y_W:0] s;
    d = $signed({1'b0, m}) - $signed({1'b0, c});
    s = $signed({1'b0, c}) + (d >>> SMOOTH_SH);
    return s[Y_W-1:0];
  endfunction

  // Registered frame-end pulse: write of the last pixel of the frame.
  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) fe <= 1'b0;
    else        fe <= pix_we && (pix_addr == LAST_PIX);
  end

  // An out-of-frame address is treated exactly like a miss.
  assign hit       = det_found && (det_addr < PIX_CNT);
  // The divider latches det_addr on this pulse, which is the SAMPLE-cycle capture.
  assign div_start = (state == ST_SAMPLE) && hit;
  assign busy      = (state != ST_IDLE);

  detect_tracker_addr_to_xy u_addr_to_xy (
    .pclk  (pclk),
    .reset (reset),
    .start (div_start),
    .addr  (det_addr),
    .done  (div_done),
    .x     (div_x),
    .y     (div_y)
  );

  // Frame FSM with registered coordinate, lock, lost-count and overrun outputs.
  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      coord_x     <= '0;
      coord_y     <= '0;
      coord_valid <= 1'b0;
      target_lock <= 1'b0;
      lost_count  <= '0;
      overrun     <= 1'b0;
    end else begin
      coord_valid <= 1'b0;
      // A frame end while busy is dropped, not queued.
      if (fe && (state != ST_IDLE)) overrun <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (fe) state <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          state <= hit ? ST_DIVIDE : ST_LOST;
        end
        ST_DIVIDE: begin
          if (div_done) begin
            state       <= ST_FILTER;
            coord_valid <= 1'b1;
            lost_count  <= '0;
            target_lock <= 1'b1;
`ifdef DETECT_SMOOTH_EN
            // First hit after loss or reset loads the measurement directly.
            if (target_lock) begin
              coord_x <= smooth_x(coord_x, div_x);
              coord_y <= smooth_y(coord_y, div_y);
            end else begin
              coord_x <= div_x;
              coord_y <= div_y;
            end
`else
            coord_x <= div_x;
            coord_y <= div_y;
`endif
          end
        end
        ST_FILTER: begin
          state <= ST_IDLE;
        end
        ST_LOST: begin
          lost_count <= sat_inc(lost_count);
          if (sat_inc(lost_count) == LOST_LIM) target_lock <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_detect_tracker.sv
// Directed bench for detect_tracker (default build or DETECT_SMOOTH_EN build).
module tb_detect_tracker;

  localparam int LAST = 640 * 480 - 1;

  logic        pclk;
  logic        reset;
  logic        pix_we;
  logic [19:0] pix_addr;
  logic        det_found;
  logic [19:0] det_addr;
  logic [9:0]  coord_x;
  logic [8:0]  coord_y;
  logic        coord_valid;
  logic        target_lock;
  logic [3:0]  lost_count;
  logic        busy;
  logic        overrun;

  int n_vec = 0;
  int n_err = 0;

  // reference state of the tracked coordinates and lock
  int m_x    = 0;
  int m_y    = 0;
  int m_lock = 0;

  detect_tracker dut (
    .pclk        (pclk),
    .reset       (reset),
    .pix_we      (pix_we),
    .pix_addr    (pix_addr),
    .det_found   (det_found),
    .det_addr    (det_addr),
    .coord_x     (coord_x),
    .coord_y     (coord_y),
    .coord_valid (coord_valid),
    .target_lock (target_lock),
    .lost_count  (lost_count),
    .busy        (busy),
    .overrun     (overrun)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_x"},       int'(coord_x),     0);
    chk({tag, "_y"},       int'(coord_y),     0);
    chk({tag, "_valid"},   int'(coord_valid), 0);
    chk({tag, "_lock"},    int'(target_lock), 0);
    chk({tag, "_lost"},    int'(lost_count),  0);
    chk({tag, "_busy"},    int'(busy),        0);
    chk({tag, "_overrun"}, int'(overrun),     0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk_zero_outputs("reset");
    repeat (2) @(posedge pclk);
    #1;
    reset = 1'b1;
    m_x = 0; m_y = 0; m_lock = 0;
  endtask

  // drive one last-pixel write; returns at #1 after the edge that samples it
  task automatic frame_end(input logic found, input int addr);
    det_found = found;
    det_addr  = 20'(addr);
    pix_addr  = 20'(LAST);
    pix_we    = 1'b1;
    @(posedge pclk);
    #1;
    pix_we   = 1'b0;
    pix_addr = '0;
  endtask

  // count edges after the frame-end edge until coord_valid; optionally inject a frame end
  task automatic wait_valid(input int inj, output int lat);
    lat = 0;
    for (int k = 1; k <= 1000; k++) begin
      @(posedge pclk);
      #1;
      if (inj > 0 && k == inj) begin
        pix_addr = 20'(LAST);
        pix_we   = 1'b1;
      end
      if (inj > 0 && k == inj + 1) begin
        pix_we   = 1'b0;
        pix_addr = '0;
      end
      if (coord_valid) begin
        lat = k;
        break;
      end
    end
    pix_we = 1'b0;
  endtask

  task automatic wait_idle();
    int ok;
    ok = 0;
    for (int k = 1; k <= 50; k++) begin
      @(posedge pclk);
      #1;
      if (!busy) begin
        ok = 1;
        break;
      end
    end
    chk("idle_timeout", ok, 1);
  endtask

  task automatic found_frame(input int addr, input int inj);
    int mx, my, ex, ey, lat;
    mx = addr % 640;
    my = addr / 640;
    ex = mx;
    ey = my;
`ifdef DETECT_SMOOTH_EN
    if (m_lock != 0) begin
      ex = m_x + ((mx - m_x) >>> 2);
      ey = m_y + ((my - m_y) >>> 2);
    end
`endif
    frame_end(1'b1, addr);
    wait_valid(inj, lat);
    chk("latency", lat, my + 4);
    chk("coord_x", int'(coord_x), ex);
    chk("coord_y", int'(coord_y), ey);
    chk("lock_on_hit", int'(target_lock), 1);
    chk("lost_on_hit", int'(lost_count), 0);
    @(posedge pclk);
    #1;
    chk("valid_pulse", int'(coord_valid), 0);
    wait_idle();
    m_x = ex;
    m_y = ey;
    m_lock = 1;
  endtask

  task automatic lost_frame(input logic found, input int addr);
    int vc, ok;
    vc = 0;
    ok = 0;
    frame_end(found, addr);
    for (int k = 1; k <= 20; k++) begin
      @(posedge pclk);
      #1;
      if (coord_valid) vc++;
      if (k >= 2 && !busy) begin
        ok = 1;
        break;
      end
    end
    chk("lost_idle_timeout", ok, 1);
    chk("lost_no_valid", vc, 0);
    chk("lost_hold_x", int'(coord_x), m_x);
    chk("lost_hold_y", int'(coord_y), m_y);
  endtask

  initial begin
    int lat;
    reset     = 1'b0;
    pix_we    = 1'b0;
    pix_addr  = '0;
    det_found = 1'b0;
    det_addr  = '0;
    @(posedge pclk);
    #1;
    do_reset();

    // 1: single hit (200,100), latency 104
    found_frame(64200, 0);

    // writes that are not a frame end do nothing
    pix_we = 1'b1; pix_addr = 20'(LAST - 1);
    @(posedge pclk); #1;
    pix_we = 1'b0; pix_addr = 20'(LAST);
    repeat (3) @(posedge pclk);
    #1;
    chk("no_fe_busy", int'(busy), 0);
    chk("no_fe_valid", int'(coord_valid), 0);

    // 2: corner addresses
    found_frame(0, 0);
    chk("between_busy", int'(busy), 0);
    found_frame(LAST, 0);
    chk("corner_overrun", int'(overrun), 0);

    // 3: eight misses drop lock, ninth saturates
    for (int i = 1; i <= 9; i++) begin
      lost_frame(1'b0, 64200);
      chk("lost_count", int'(lost_count), (i > 8) ? 8 : i);
      chk("lost_lock", int'(target_lock), (i < 8) ? 1 : 0);
    end
    m_lock = 0;

    // 4: frame end during a long divide -> sticky overrun, result intact
    found_frame(400 * 640 + 17, 50);
    chk("overrun_set", int'(overrun), 1);
    found_frame(64200, 0);
    chk("overrun_sticky", int'(overrun), 1);

    // 5: smoothing / direct load
    do_reset();
    found_frame(100 * 640 + 100, 0);
    found_frame(60 * 640 + 200, 0);
`ifdef DETECT_SMOOTH_EN
    chk("smooth_x_hand", int'(coord_x), 125);
    chk("smooth_y_hand", int'(coord_y), 90);
`else
    chk("load_x_hand", int'(coord_x), 200);
    chk("load_y_hand", int'(coord_y), 60);
`endif
    do_reset();
    found_frame(60 * 640 + 200, 0);
    chk("reload_x", int'(coord_x), 200);
    chk("reload_y", int'(coord_y), 60);

    // 6: out-of-frame address counts as a miss
    do_reset();
    lost_frame(1'b1, 640 * 480);
    chk("oob_lost", int'(lost_count), 1);
    chk("oob_lock", int'(target_lock), 0);

    // reset asserted mid-divide clears everything asynchronously
    frame_end(1'b1, 400 * 640 + 17);
    repeat (20) @(posedge pclk);
    #1;
    chk("mid_div_busy", int'(busy), 1);
    reset = 1'b0;
    #1;
    chk_zero_outputs("abort");
    #2;
    reset = 1'b1;
    wait_valid(0, lat);
    chk("abort_no_valid", lat, 0);
    chk("abort_idle", int'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
